// File: rtl/acc_cpu_core_if.sv
// -----------------------------------------------------------------------------
// acc_cpu_core_if
//   Program/data load port of the accumulator CPU core. The front-end (UART
//   bridge or testbench) is the master and streams beats into the core. The
//   core is the slave and accepts one beat per cycle while it is in load mode.
//
//   Ld_sel    master->slave  target memory: 0 = IMEM, 1 = DMEM
//   Ld_valid  master->slave  beat valid
//   Ld_data   master->slave  beat payload (LD_W bits)
//   Ld_ready  slave->master  core is in load mode and accepts beats
// -----------------------------------------------------------------------------
interface acc_cpu_core_if #(
  parameter int LD_W = 8
);
  logic            Ld_sel;
  logic            Ld_valid;
  logic [LD_W-1:0] Ld_data;
  logic            Ld_ready;

  modport master (output Ld_sel, output Ld_valid, output Ld_data, input  Ld_ready);
  modport slave  (input  Ld_sel, input  Ld_valid, input  Ld_data, output Ld_ready);
endinterface

// File: rtl/acc_cpu_core.sv
// -----------------------------------------------------------------------------
// acc_cpu_core
//   Parametrised accumulator CPU. Every instruction takes three cycles:
//   FETCH (IR <= IMEM[PC]), READ (MDR <= DMEM[A]) and EXEC (results are
//   committed on the closing edge). A level-sensitive Load input pulls the
//   core into LOAD from any state. In LOAD, beats on the load port fill IMEM
//   or DMEM sequentially from address 0.
//
//   Clk, Reset     clock, asynchronous active-high reset
//   Load           level: load mode, overrides everything else
//   Start          starts execution at PC=0 from IDLE or HALT
//   ld             load port (slave side of acc_cpu_core_if)
//   Dbg_addr/data  combinational DMEM read port
//   Instruction    IR register
//   Pc, Acc        program counter, accumulator
//   Zero, Carry    flags
//   Busy, Halted   state is FETCH/READ/EXEC, state is HALT
//
//   Both memories are reset, so an unloaded program is all HLT.
// -----------------------------------------------------------------------------
module acc_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int LD_W   = (DATA_W > ADDR_W + 3) ? DATA_W : ADDR_W + 3
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Load,
  input  logic                Start,
  acc_cpu_core_if.slave       ld,
  input  logic [ADDR_W-1:0]   Dbg_addr,
  output logic [DATA_W-1:0]   Dbg_data,
  output logic [ADDR_W+2:0]   Instruction,
  output logic [ADDR_W-1:0]   Pc,
  output logic [DATA_W-1:0]   Acc,
  output logic                Zero,
  output logic                Carry,
  output logic                Busy,
  output logic                Halted
);

  localparam int IR_W  = ADDR_W + 3;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_READ,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q,    state_d;
  logic [ADDR_W-1:0]   pc_q,       pc_d;
  logic [IR_W-1:0]     ir_q,       ir_d;
  logic [DATA_W-1:0]   mdr_q,      mdr_d;
  logic [DATA_W-1:0]   acc_q,      acc_d;
  logic                zero_q,     zero_d;
  logic                carry_q,    carry_d;
  logic [ADDR_W-1:0]   imem_ptr_q, imem_ptr_d;
  logic [ADDR_W-1:0]   dmem_ptr_q, dmem_ptr_d;

  // Status outputs are registered from the next state so they line up with
  // the state register without any decode after the flops.
  logic                busy_q;
  logic                halted_q;
  logic                ld_ready_q;

  logic [IR_W-1:0]     imem_q [DEPTH];
  logic [DATA_W-1:0]   dmem_q [DEPTH];

  // Memory write ports, computed alongside the next-state logic.
  logic                imem_we;
  logic [ADDR_W-1:0]   imem_waddr;
  logic [IR_W-1:0]     imem_wdata;
  logic                dmem_we;
  logic [ADDR_W-1:0]   dmem_waddr;
  logic [DATA_W-1:0]   dmem_wdata;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  opcode_e             op;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W:0]     sum;

  assign op      = opcode_e'(ir_q[IR_W-1:ADDR_W]);
  assign operand = ir_q[ADDR_W-1:0];
  assign sum     = {1'b0, acc_q} + {1'b0, mdr_q};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through
    // the case statements can leave one unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    mdr_d      = mdr_q;
    acc_d      = acc_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    imem_ptr_d = imem_ptr_q;
    dmem_ptr_d = dmem_ptr_q;
    imem_we    = 1'b0;
    imem_waddr = imem_ptr_q;
    imem_wdata = ld.Ld_data[IR_W-1:0];
    dmem_we    = 1'b0;
    dmem_waddr = operand;
    dmem_wdata = acc_q;

    if (Load && (state_q != S_LOAD)) begin
      // Entering load mode abandons whatever was in flight, including an
      // EXEC that would otherwise commit on this edge.
      state_d    = S_LOAD;
      imem_ptr_d = '0;
      dmem_ptr_d = '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          // Ld_ready is high throughout LOAD, so a valid beat is accepted.
          if (ld.Ld_valid) begin
            if (!ld.Ld_sel) begin
              imem_we    = 1'b1;
              imem_waddr = imem_ptr_q;
              imem_ptr_d = imem_ptr_q + ADDR_W'(1);
            end else begin
              dmem_we    = 1'b1;
              dmem_waddr = dmem_ptr_q;
              dmem_wdata = ld.Ld_data[DATA_W-1:0];
              dmem_ptr_d = dmem_ptr_q + ADDR_W'(1);
            end
          end
          if (!Load) state_d = S_IDLE;
        end

        S_IDLE, S_HALT: begin
          if (Start) begin
            state_d = S_FETCH;
            pc_d    = '0;
            acc_d   = '0;
            zero_d  = 1'b0;
            carry_d = 1'b0;
          end
        end

        S_FETCH: begin
          ir_d    = imem_q[pc_q];
          state_d = S_READ;
        end

        S_READ: begin
          mdr_d   = dmem_q[operand];
          state_d = S_EXEC;
        end

        S_EXEC: begin
          state_d = S_FETCH;
          pc_d    = pc_q + ADDR_W'(1);
          unique case (op)
            OP_HLT: begin
              state_d = S_HALT;
              pc_d    = pc_q;
            end
            OP_SKZ: begin
              if (acc_q == '0) pc_d = pc_q + ADDR_W'(2);
            end
            OP_ADD: begin
              acc_d   = sum[DATA_W-1:0];
              carry_d = sum[DATA_W];
              zero_d  = (acc_d == '0);
            end
            OP_AND: begin
              acc_d  = acc_q & mdr_q;
              zero_d = (acc_d == '0);
            end
            OP_XOR: begin
              acc_d  = acc_q ^ mdr_q;
              zero_d = (acc_d == '0);
            end
            OP_LDA: begin
              acc_d  = mdr_q;
              zero_d = (acc_d == '0);
            end
            OP_STO: begin
              dmem_we    = 1'b1;
              dmem_waddr = operand;
              dmem_wdata = acc_q;
            end
            OP_JMP: begin
              pc_d = operand;
            end
          endcase
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers and memories
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      mdr_q      <= '0;
      acc_q      <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      imem_ptr_q <= '0;
      dmem_ptr_q <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      ld_ready_q <= 1'b0;
      // NOTE: both memories are built from resettable flops rather than RAM
      // macros because reset must leave them all-zero (an all-HLT program).
      for (int i = 0; i < DEPTH; i++) begin
        imem_q[i] <= '0;
        dmem_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values computed above, independent of statement order.
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mdr_q      <= mdr_d;
      acc_q      <= acc_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      imem_ptr_q <= imem_ptr_d;
      dmem_ptr_q <= dmem_ptr_d;
      busy_q     <= (state_d == S_FETCH) || (state_d == S_READ) || (state_d == S_EXEC);
      halted_q   <= (state_d == S_HALT);
      ld_ready_q <= (state_d == S_LOAD);
      if (imem_we) imem_q[imem_waddr] <= imem_wdata;
      if (dmem_we) dmem_q[dmem_waddr] <= dmem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ld.Ld_ready   = ld_ready_q;
  assign Dbg_data      = dmem_q[Dbg_addr];
  assign Instruction   = ir_q;
  assign Pc            = pc_q;
  assign Acc           = acc_q;
  assign Zero          = zero_q;
  assign Carry         = carry_q;
  assign Busy          = busy_q;
  assign Halted        = halted_q;

endmodule
